spi_frame_capture: RTL and testbench

SPI_FRAME_CAPTURE -- requirements
Module: spi_frame_capture

---
 rtl/spi_frame_pkg.sv | 18 +
 rtl/spi_frame_capture_if.sv | 29 ++
 rtl/sync2.sv | 25 ++
 rtl/spi_frame_capture.sv | 140 ++++++++++++++
 tb/tb_spi_frame_capture.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/spi_frame_pkg.sv
// Shared types for the SPI frame capture block: word width, frame struct and FSM states.
package spi_frame_pkg;

  localparam int WORD_W = 16;

  typedef struct packed {
    logic [WORD_W-1:0] p1;
    logic [WORD_W-1:0] p2;
  } frame_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOADING = 2'd1,
    SETTLE  = 2'd2,
    HOLD    = 2'd3
  } fstate_t;

endpackage

// File: rtl/spi_frame_capture_if.sv
// Bus bundle between the MCU/SPI receiver/consumer side and spi_frame_capture.
interface spi_frame_capture_if
  import spi_frame_pkg::*;
#(
  parameter int CNT_W = 8
) ();

  logic              load;
  logic [WORD_W-1:0] p1;
  logic [WORD_W-1:0] p2;
  logic              frame_ready;
  logic              overrun_clr;
  logic              frame_valid;
  logic [WORD_W-1:0] p1_out;
  logic [WORD_W-1:0] p2_out;
  logic [CNT_W-1:0]  frame_count;
  logic              overrun;

  modport master (
    output load, p1, p2, frame_ready, overrun_clr,
    input  frame_valid, p1_out, p2_out, frame_count, overrun
  );

  modport slave (
    input  load, p1, p2, frame_ready, overrun_clr,
    output frame_valid, p1_out, p2_out, frame_count, overrun
  );

endinterface

// File: rtl/sync2.sv
// Two-flop synchronizer with asynchronous active-low reset (both flops clear to 0).
module sync2 (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic meta_r;
  logic sync_r;

  // Metastability settling chain.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_r <= 1'b0;
      sync_r <= 1'b0;
    end else begin
      meta_r <= d;
      sync_r <= meta_r;
    end
  end

  assign q = sync_r;

endmodule

// File: rtl/spi_frame_capture.sv
// Captures p1/p2 words when the MCU load strobe falls and presents them with a valid/ready handshake.
// Optional change-only capture is enabled by defining SPI_FRAME_CHANGE_ONLY_EN.
module spi_frame_capture
  import spi_frame_pkg::*;
#(
  parameter int WORD_W = 16,
  parameter int CNT_W  = 8
) (
  input logic              clk,
  input logic              reset_n,
  spi_frame_capture_if.slave bus
);

  if (WORD_W != 16) begin : g_word_w_chk
    $error("spi_frame_capture supports WORD_W = 16 only");
  end

  fstate_t          state_r;
  fstate_t          state_nxt_s;
  logic             load_s;
  logic             load_prev_r;
  logic             seen_r;
  logic             fall_s;
  logic             hs_s;
  logic             set_ovr_s;
  logic             capture_s;
  logic             same_s;
  logic             valid_r;
  frame_t           cap_r;
  logic [CNT_W-1:0] cnt_r;
  logic             overrun_r;

  sync2 u_load_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (bus.load),
    .q       (load_s)
  );

  assign fall_s    = load_prev_r & ~load_s;
  assign hs_s      = valid_r & bus.frame_ready;
  assign capture_s = (state_r == SETTLE) && (state_nxt_s == HOLD);

`ifdef SPI_FRAME_CHANGE_ONLY_EN
  frame_t last_r;

  // Remembers the last frame the consumer accepted, for duplicate suppression.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_r <= '0;
    end else if (hs_s) begin
      last_r <= cap_r;
    end
  end

  assign same_s = ({bus.p1, bus.p2} == last_r);
`else
  assign same_s = 1'b0;
`endif

  // Next-state and overrun-event decode.
  always_comb begin
    state_nxt_s = state_r;
    set_ovr_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (load_s) state_nxt_s = LOADING;
        else        state_nxt_s = IDLE;
      end
      LOADING: begin
        // seen_r filters a load that was high for only one synchronized sample.
        if (load_s)      state_nxt_s = LOADING;
        else if (seen_r) state_nxt_s = SETTLE;
        else             state_nxt_s = IDLE;
      end
      SETTLE: begin
        if (same_s) state_nxt_s = IDLE;
        else        state_nxt_s = HOLD;
      end
      HOLD: begin
        if (hs_s) begin
          if (load_s) state_nxt_s = LOADING;
          else        state_nxt_s = IDLE;
        end else begin
          state_nxt_s = HOLD;
          set_ovr_s   = fall_s;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        set_ovr_s   = 1'b0;
      end
    endcase
  end

  // FSM state and load history.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= IDLE;
      load_prev_r <= 1'b0;
      seen_r      <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      load_prev_r <= load_s;
      seen_r      <= load_s && (state_r != IDLE);
    end
  end

  // Output datapath: valid flag, captured words, accepted-frame counter and sticky overrun.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_r   <= 1'b0;
      cap_r     <= '0;
      cnt_r     <= '0;
      overrun_r <= 1'b0;
    end else begin
      valid_r <= (state_nxt_s == HOLD);
      if (capture_s) begin
        cap_r.p1 <= bus.p1;
        cap_r.p2 <= bus.p2;
      end
      if (hs_s) begin
        cnt_r <= cnt_r + CNT_W'(1);
      end
      // A new drop wins over a simultaneous clear.
      if (set_ovr_s) begin
        overrun_r <= 1'b1;
      end else if (bus.overrun_clr) begin
        overrun_r <= 1'b0;
      end
    end
  end

  assign bus.frame_valid = valid_r;
  assign bus.p1_out      = cap_r.p1;
  assign bus.p2_out      = cap_r.p2;
  assign bus.frame_count = cnt_r;
  assign bus.overrun     = overrun_r;

endmodule

// File: tb/tb_spi_frame_capture.sv
// Self-checking bench for spi_frame_capture: directed scenarios plus randomized frames vs a frame-level model.
module tb_spi_frame_capture;

  logic clk = 1'b0;
  logic reset_n;
  int   total = 0;
  int   bad   = 0;

  // Frame-level reference model state.
  int          m_cnt;
  logic [31:0] m_last;
  logic        m_ovr;

`ifdef SPI_FRAME_CHANGE_ONLY_EN
  localparam bit CHG = 1'b1;
`else
  localparam bit CHG = 1'b0;
`endif

  spi_frame_capture_if #(.CNT_W(8)) bus ();

  spi_frame_capture #(.WORD_W(16), .CNT_W(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One complete frame with the consumer ready; the model decides whether it is presented.
  task automatic run_frame(input logic [15:0] a, input logic [15:0] b, input int hi);
    int   pulses;
    int   first;
    logic pres;
    pres = !(CHG && ({a, b} == m_last));
    bus.p1   = a;
    bus.p2   = b;
    bus.load = 1'b1;
    repeat (hi) tick();
    bus.load = 1'b0;
    pulses = 0;
    first  = 0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (bus.frame_valid === 1'b1) begin
        pulses++;
        if (first == 0) first = k;
        check("frame_p1", 32'(bus.p1_out), 32'(a));
        check("frame_p2", 32'(bus.p2_out), 32'(b));
      end
    end
    check("frame_pulses", 32'(pulses), pres ? 32'd1 : 32'd0);
    if (pres) begin
      check("frame_latency", 32'((first == 4) || (first == 5)), 32'd1);
      m_cnt  = (m_cnt + 1) % 256;
      m_last = {a, b};
    end
    check("frame_count", 32'(bus.frame_count), 32'(m_cnt));
    check("frame_overrun", 32'(bus.overrun), 32'(m_ovr));
  endtask

  initial begin
    int first;
    int pulses;
    logic seen;

    reset_n         = 1'b0;
    bus.load        = 1'b0;
    bus.p1          = 16'h0000;
    bus.p2          = 16'h0000;
    bus.frame_ready = 1'b0;
    bus.overrun_clr = 1'b0;
    m_cnt  = 0;
    m_last = 32'h0;
    m_ovr  = 1'b0;

    repeat (2) tick();
    check("rst_valid", 32'(bus.frame_valid), 32'd0);
    check("rst_p1", 32'(bus.p1_out), 32'd0);
    check("rst_p2", 32'(bus.p2_out), 32'd0);
    check("rst_count", 32'(bus.frame_count), 32'd0);
    check("rst_overrun", 32'(bus.overrun), 32'd0);
    reset_n = 1'b1;
    repeat (2) tick();

    // Long frame, held without handshake, latency measured from the load fall.
    bus.p1   = 16'h0102;
    bus.p2   = 16'h0304;
    bus.load = 1'b1;
    repeat (40) tick();
    bus.load = 1'b0;
    first = 0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if ((bus.frame_valid === 1'b1) && (first == 0)) first = k;
    end
    check("f1_latency", 32'((first == 4) || (first == 5)), 32'd1);
    check("f1_valid", 32'(bus.frame_valid), 32'd1);
    check("f1_p1", 32'(bus.p1_out), 32'h0102);
    check("f1_p2", 32'(bus.p2_out), 32'h0304);

    // Second frame completes while the first is still held: dropped.
    bus.p1   = 16'hAAAA;
    bus.p2   = 16'h5555;
    bus.load = 1'b1;
    repeat (5) tick();
    bus.load = 1'b0;
    repeat (8) tick();
    m_ovr = 1'b1;
    check("drop_valid", 32'(bus.frame_valid), 32'd1);
    check("drop_p1", 32'(bus.p1_out), 32'h0102);
    check("drop_p2", 32'(bus.p2_out), 32'h0304);
    check("drop_overrun", 32'(bus.overrun), 32'(m_ovr));
    bus.overrun_clr = 1'b1;
    tick();
    bus.overrun_clr = 1'b0;
    m_ovr = 1'b0;
    check("ovr_clear", 32'(bus.overrun), 32'(m_ovr));

    // Clear on the very edge a new drop is flagged: the drop wins.
    bus.load = 1'b1;
    repeat (3) tick();
    bus.load = 1'b0;
    tick();
    tick();
    bus.overrun_clr = 1'b1;
    tick();
    bus.overrun_clr = 1'b0;
    check("ovr_set_wins", 32'(bus.overrun), 32'd1);
    bus.overrun_clr = 1'b1;
    tick();
    bus.overrun_clr = 1'b0;
    check("ovr_clear2", 32'(bus.overrun), 32'd0);

    // Accept the held frame.
    bus.frame_ready = 1'b1;
    tick();
    m_cnt  = 1;
    m_last = {16'h0102, 16'h0304};
    check("hs_valid", 32'(bus.frame_valid), 32'd0);
    check("hs_count", 32'(bus.frame_count), 32'(m_cnt));
    repeat (3) tick();

    // Duplicate frames (suppressed only in change-only builds), then a changed one.
    run_frame(16'h1234, 16'h5678, 3);
    run_frame(16'h1234, 16'h5678, 3);
    run_frame(16'h1234, 16'h5679, 3);

    // One-clock load pulse must not produce a frame.
    bus.p1   = 16'($urandom_range(0, 65535));
    bus.p2   = 16'($urandom_range(0, 65535));
    bus.load = 1'b1;
    tick();
    bus.load = 1'b0;
    pulses = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (bus.frame_valid !== 1'b0) pulses++;
    end
    check("short_pulse_valid", 32'(pulses), 32'd0);
    check("short_pulse_overrun", 32'(bus.overrun), 32'd0);
    check("short_pulse_noX", 32'($isunknown({bus.frame_valid, bus.p1_out, bus.p2_out,
                                              bus.frame_count, bus.overrun})), 32'd0);
    check("short_pulse_count", 32'(bus.frame_count), 32'(m_cnt));

    // 256 random frames with the consumer always ready: counter wraps through 0x00.
    for (int i = 0; i < 256; i++) begin
      run_frame(16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)),
                int'($urandom_range(2, 6)));
    end

    // Reset while holding an unaccepted frame.
    bus.frame_ready = 1'b0;
    bus.p1   = 16'($urandom_range(1, 65535));
    bus.p2   = 16'($urandom_range(1, 65535));
    bus.load = 1'b1;
    repeat (3) tick();
    bus.load = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (bus.frame_valid === 1'b1) seen = 1'b1;
    end
    check("hold_before_reset", 32'(seen), 32'd1);
    reset_n = 1'b0;
    #1;
    m_cnt  = 0;
    m_last = 32'h0;
    m_ovr  = 1'b0;
    check("async_rst_valid", 32'(bus.frame_valid), 32'd0);
    check("async_rst_p1", 32'(bus.p1_out), 32'd0);
    check("async_rst_count", 32'(bus.frame_count), 32'(m_cnt));
    check("async_rst_overrun", 32'(bus.overrun), 32'(m_ovr));
    tick();
    tick();
    reset_n = 1'b1;
    pulses = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (bus.frame_valid !== 1'b0) pulses++;
    end
    check("post_rst_no_valid", 32'(pulses), 32'd0);

    // Recovery after reset.
    bus.frame_ready = 1'b1;
    run_frame(16'hC0DE, 16'hF00D, 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
